// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one slow-memory port between the I-cache and D-cache
// line-fill / write-back interfaces. One requester is granted per
// transaction; its command is latched on grant and the memory response is
// routed back only to that requester.
//
// Build option: define MEM_ARB_DPRIO_EN for fixed priority (D wins every
// tie). Without it, ties are broken round-robin using the `last` pointer.
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              proc_reset,
  // I-cache port
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic [DATA_W-1:0] i_mem_rdata,
  output logic              i_mem_ready,
  // D-cache port
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_wdata,
  output logic [DATA_W-1:0] d_mem_rdata,
  output logic              d_mem_ready,
  // slow-memory port
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY_I = 2'b01,
    BUSY_D = 2'b10
  } state_t;

  state_t            state_r;
  state_t            next_state_s;
  logic              pend_i_s;
  logic              pend_d_s;
  logic              grant_i_s;
  logic              grant_d_s;
  logic              done_s;
  logic              mem_read_r;
  logic              mem_write_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;

`ifndef MEM_ARB_DPRIO_EN
  // Requester served by the most recent completed transaction: 0 = I, 1 = D.
  logic              last_r;
`endif

  assign pend_i_s = i_mem_read | i_mem_write;
  assign pend_d_s = d_mem_read | d_mem_write;

  // Arbitration and next-state: grant only from IDLE, release on mem_ready.
  always_comb begin
    next_state_s = state_r;
    grant_i_s    = 1'b0;
    grant_d_s    = 1'b0;
    done_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (pend_i_s && pend_d_s) begin
`ifdef MEM_ARB_DPRIO_EN
          grant_d_s = 1'b1;
`else
          // The requester not served last wins the tie.
          if (last_r == 1'b0) begin
            grant_d_s = 1'b1;
          end else begin
            grant_i_s = 1'b1;
          end
`endif
        end else if (pend_d_s) begin
          grant_d_s = 1'b1;
        end else if (pend_i_s) begin
          grant_i_s = 1'b1;
        end else begin
          grant_i_s = 1'b0;
          grant_d_s = 1'b0;
        end
        if (grant_d_s) begin
          next_state_s = BUSY_D;
        end else if (grant_i_s) begin
          next_state_s = BUSY_I;
        end else begin
          next_state_s = IDLE;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready) begin
          // Always pass through IDLE so the requester can drop its request.
          next_state_s = IDLE;
          done_s       = 1'b1;
        end else begin
          next_state_s = state_r;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State register and latched memory command.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_r     <= IDLE;
      mem_read_r  <= 1'b0;
      mem_write_r <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
    end else begin
      state_r <= next_state_s;
      if (grant_i_s) begin
        mem_read_r  <= i_mem_read;
        mem_write_r <= i_mem_write;
        mem_addr_r  <= i_mem_addr;
        mem_wdata_r <= i_mem_wdata;
      end else if (grant_d_s) begin
        mem_read_r  <= d_mem_read;
        mem_write_r <= d_mem_write;
        mem_addr_r  <= d_mem_addr;
        mem_wdata_r <= d_mem_wdata;
      end else if (done_s) begin
        mem_read_r  <= 1'b0;
        mem_write_r <= 1'b0;
      end
    end
  end

`ifndef MEM_ARB_DPRIO_EN
  // Round-robin pointer: remember who completed the last transaction.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      last_r <= 1'b0;
    end else if (done_s) begin
      last_r <= (state_r == BUSY_D);
    end
  end
`endif

  // Response routing: only the granted requester sees ready and read data.
  always_comb begin
    i_mem_ready = 1'b0;
    i_mem_rdata = '0;
    d_mem_ready = 1'b0;
    d_mem_rdata = '0;
    if ((state_r == BUSY_I) && mem_ready) begin
      i_mem_ready = 1'b1;
      i_mem_rdata = mem_rdata;
    end else if ((state_r == BUSY_D) && mem_ready) begin
      d_mem_ready = 1'b1;
      d_mem_rdata = mem_rdata;
    end else begin
      i_mem_ready = 1'b0;
      d_mem_ready = 1'b0;
    end
  end

  assign mem_read  = mem_read_r;
  assign mem_write = mem_write_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: two randomized requesters, a randomized slow
// memory, and a transaction-level scoreboard that predicts grant order,
// the latched command and response routing.
module tb_mem_arbiter;

  localparam int AW = 28;
  localparam int DW = 128;
  localparam int NTX = 40;

  typedef struct packed {
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic          who;   // 0 = I, 1 = D
    logic [DW-1:0] data;
  } resp_t;

  logic          clk = 1'b0;
  logic          proc_reset;
  logic          i_mem_read, i_mem_write, d_mem_read, d_mem_write;
  logic [AW-1:0] i_mem_addr, d_mem_addr;
  logic [DW-1:0] i_mem_wdata, d_mem_wdata;
  logic [DW-1:0] i_mem_rdata, d_mem_rdata;
  logic          i_mem_ready, d_mem_ready;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  int n_vec = 0;
  int n_err = 0;

  // Scoreboard state
  req_t  i_q[$];
  req_t  d_q[$];
  resp_t resp_q[$];
  bit    mon_en = 1'b0;
  bit    mem_en = 1'b0;
  bit    stray_go = 1'b0;
  bit    busy = 1'b0;
  bit    start_pend = 1'b0;
  bit    cur_who = 1'b0;
  bit    nxt_who = 1'b0;
  bit    last_d = 1'b0;   // served last: 0 = I (reset value), 1 = D
  req_t  cur_cmd;
  req_t  nxt_cmd;
  int    gnt_cnt_i = 0;
  int    gnt_cnt_d = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .proc_reset(proc_reset),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
    .i_mem_addr(i_mem_addr), .i_mem_wdata(i_mem_wdata),
    .i_mem_rdata(i_mem_rdata), .i_mem_ready(i_mem_ready),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
    .d_mem_addr(d_mem_addr), .d_mem_wdata(d_mem_wdata),
    .d_mem_rdata(d_mem_rdata), .d_mem_ready(d_mem_ready),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One requester: issues NTX transactions, holds each until its ready,
  // scrambles addr/wdata after grant, sometimes re-requests back-to-back.
  task automatic run_req(input bit is_d);
    req_t r;
    int   k;
    int   waited;
    int   g0;
    bit   scr;
    bit   got;
    for (int t = 0; t < NTX; t++) begin
      k = (t == 0) ? 0 : int'($urandom_range(0, 3));
      repeat (k) begin @(posedge clk); #1; end
      r.wr    = is_d ? 1'($urandom_range(0, 1)) : 1'($urandom_range(0, 7) == 0);
      r.rd    = ~r.wr;
      r.addr  = {is_d, 27'($urandom)};
      r.wdata = rnd_line();
      if (is_d) begin
        d_mem_read = r.rd; d_mem_write = r.wr; d_mem_addr = r.addr; d_mem_wdata = r.wdata;
        d_q.push_back(r);
        g0 = gnt_cnt_d;
      end else begin
        i_mem_read = r.rd; i_mem_write = r.wr; i_mem_addr = r.addr; i_mem_wdata = r.wdata;
        i_q.push_back(r);
        g0 = gnt_cnt_i;
      end
      waited = 0;
      scr    = 1'b0;
      got    = 1'b0;
      while (!got) begin
        @(negedge clk);
        if (is_d ? d_mem_ready : i_mem_ready) begin
          got = 1'b1;
        end else begin
          waited++;
          if (waited > 300) begin
            n_vec++;
            n_err++;
            $display("FAIL req_timeout_%s: got no ready, required ready within 300 cycles", is_d ? "d" : "i");
            got = 1'b1;
          end else if (!scr && ((is_d ? gnt_cnt_d : gnt_cnt_i) != g0) && ($urandom_range(0, 1) == 1)) begin
            scr = 1'b1;
            if (is_d) begin d_mem_addr = 28'($urandom); d_mem_wdata = rnd_line(); end
            else begin i_mem_addr = 28'($urandom); i_mem_wdata = rnd_line(); end
          end
        end
      end
      @(posedge clk); #1;
      if (is_d) begin d_mem_read = 1'b0; d_mem_write = 1'b0; end
      else begin i_mem_read = 1'b0; i_mem_write = 1'b0; end
    end
  endtask

  // Slow memory model: answers each command after 1..5 cycles with random data.
  initial begin
    resp_t rs;
    int    dly;
    mem_ready = 1'b0;
    mem_rdata = '0;
    wait (mem_en);
    while (mem_en) begin
      @(negedge clk); #1;
      if (mem_en) begin
        mem_rdata = rnd_line();
        if (mem_read || mem_write) begin
          dly = int'($urandom_range(1, 5));
          repeat (dly) @(posedge clk);
          #1;
          rs.who    = cur_who;
          rs.data   = rnd_line();
          mem_rdata = rs.data;
          mem_ready = 1'b1;
          resp_q.push_back(rs);
          @(posedge clk); #1;
          mem_ready = 1'b0;
        end
      end
    end
    wait (stray_go);
    mem_rdata = {16{8'hA5}};
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
  end

  // Monitor: predicts grants from the pending set and round-robin rule,
  // checks the memory command, and checks routing of every response.
  initial begin
    bit    entry_idle;
    bit    pi, pd;
    resp_t rs;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        entry_idle = !busy && !start_pend;
        if (start_pend) begin
          start_pend = 1'b0;
          busy       = 1'b1;
          cur_who    = nxt_who;
          cur_cmd    = nxt_cmd;
          if (cur_who) gnt_cnt_d++; else gnt_cnt_i++;
        end
        if (busy) begin
          check(cur_who ? "cmd_read_d" : "cmd_read_i", mem_read, cur_cmd.rd);
          check(cur_who ? "cmd_write_d" : "cmd_write_i", mem_write, cur_cmd.wr);
          check(cur_who ? "cmd_addr_d" : "cmd_addr_i", mem_addr, cur_cmd.addr);
          check(cur_who ? "cmd_wdata_d" : "cmd_wdata_i", mem_wdata, cur_cmd.wdata);
        end else begin
          check("idle_cmd", {mem_read, mem_write}, 2'b00);
        end
        if (busy && mem_ready) begin
          if (resp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL resp_queue: got empty queue, required a pending memory response");
          end else begin
            rs = resp_q.pop_front();
            check("ready_i", i_mem_ready, !rs.who);
            check("ready_d", d_mem_ready, rs.who);
            check("rdata_i", i_mem_rdata, rs.who ? '0 : rs.data);
            check("rdata_d", d_mem_rdata, rs.who ? rs.data : '0);
          end
          last_d = cur_who;
          busy   = 1'b0;
        end else begin
          check("noready", {i_mem_ready, d_mem_ready}, 2'b00);
          check("nordata_i", i_mem_rdata, '0);
          check("nordata_d", d_mem_rdata, '0);
        end
        if (entry_idle) begin
          pi = i_mem_read | i_mem_write;
          pd = d_mem_read | d_mem_write;
          if (pi || pd) begin
`ifdef MEM_ARB_DPRIO_EN
            nxt_who = pd;
`else
            nxt_who = (pi && pd) ? !last_d : pd;
`endif
            if ((nxt_who ? d_q.size() : i_q.size()) == 0) begin
              n_vec++;
              n_err++;
              $display("FAIL req_queue: got empty queue, required an issued request");
            end else begin
              nxt_cmd    = nxt_who ? d_q.pop_front() : i_q.pop_front();
              start_pend = 1'b1;
            end
          end
        end
      end
    end
  end

  // Main sequence: reset checks, random traffic, reset during BUSY_D.
  initial begin
    proc_reset  = 1'b1;
    i_mem_read  = 1'b0; i_mem_write = 1'b0; i_mem_addr = '0; i_mem_wdata = '0;
    d_mem_read  = 1'b0; d_mem_write = 1'b0; d_mem_addr = '0; d_mem_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_read", mem_read, 1'b0);
    check("rst_mem_write", mem_write, 1'b0);
    check("rst_mem_addr", mem_addr, '0);
    check("rst_mem_wdata", mem_wdata, '0);
    check("rst_ready", {i_mem_ready, d_mem_ready}, 2'b00);
    check("rst_rdata_i", i_mem_rdata, '0);
    check("rst_rdata_d", d_mem_rdata, '0);
    @(posedge clk); #1;
    proc_reset = 1'b0;
    mon_en     = 1'b1;
    mem_en     = 1'b1;
    fork
      run_req(1'b0);
      run_req(1'b1);
    join
    repeat (4) @(posedge clk);
    #1;
    mon_en = 1'b0;
    mem_en = 1'b0;
    check("end_queues_empty", i_q.size() + d_q.size() + resp_q.size(), 0);

    // D read granted, then reset mid-transaction with a late memory ready.
    d_mem_read = 1'b1; d_mem_write = 1'b0; d_mem_addr = 28'h0000100; d_mem_wdata = {8{16'h1234}};
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_pre_read", mem_read, 1'b1);
    check("abort_pre_addr", mem_addr, 28'h0000100);
    @(posedge clk); #1;
    proc_reset = 1'b1;
    d_mem_read = 1'b0;
    @(posedge clk); #1;
    proc_reset = 1'b0;
    @(negedge clk);
    check("abort_cmd", {mem_read, mem_write}, 2'b00);
    check("abort_addr", mem_addr, '0);
    check("abort_wdata", mem_wdata, '0);
    @(posedge clk); #1;
    stray_go = 1'b1;
    #1;
    @(negedge clk);
    check("stray_ready", {i_mem_ready, d_mem_ready}, 2'b00);
    check("stray_rdata_i", i_mem_rdata, '0);
    check("stray_rdata_d", d_mem_rdata, '0);
    check("stray_cmd", {mem_read, mem_write}, 2'b00);
    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
